pc_btb_gen: RTL

Parametrised successor to the pipeline PC register: holds the fetch PC and generates the next PC from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Sits at the IF stage. Receives redirects (mispredict, exception, flush target) and BTB training updates from EX. Replaces the fixed "flush to reset vector" behaviour with redirect-to-target.

---
 rtl/pc_btb_gen.sv | 115 +++++++++++
 1 files changed

// File: rtl/pc_btb_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_btb_gen
// Purpose  : IF-stage fetch PC register with direct-mapped BTB next-PC
//            prediction (2-bit saturating counters) and redirect-to-target.
// Revision : 1.0 - initial release
// ============================================================================
module pc_btb_gen #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'h0040_0000),
    parameter int              BTB_ENTRIES = 16,
    parameter int              IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] npc
);

    localparam int c_tag_w = XLEN - IDX_W - 2;
    localparam int c_tgt_w = XLEN - 2;

    logic [XLEN-1:0]        pc_q, pc_d;
    logic [BTB_ENTRIES-1:0] valid_q, valid_d;
    logic [c_tag_w-1:0]     tag_q [BTB_ENTRIES];
    logic [c_tag_w-1:0]     tag_d [BTB_ENTRIES];
    logic [c_tgt_w-1:0]     tgt_q [BTB_ENTRIES];
    logic [c_tgt_w-1:0]     tgt_d [BTB_ENTRIES];
    logic [1:0]             ctr_q [BTB_ENTRIES];
    logic [1:0]             ctr_d [BTB_ENTRIES];

    logic [IDX_W-1:0]   w_lk_idx, w_up_idx;
    logic [c_tag_w-1:0] w_lk_tag, w_up_tag;
    logic               w_up_hit;
    logic               w_unused;

    // Low address bits are always forced to zero, so they never participate.
    assign w_unused = ^{redirect_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    assign w_lk_idx = pc_q[IDX_W+1:2];
    assign w_lk_tag = pc_q[XLEN-1:IDX_W+2];
    assign w_up_idx = upd_pc[IDX_W+1:2];
    assign w_up_tag = upd_pc[XLEN-1:IDX_W+2];
    assign w_up_hit = valid_q[w_up_idx] && (tag_q[w_up_idx] == w_up_tag);

    assign pc         = pc_q;
    assign pred_hit   = valid_q[w_lk_idx] && (tag_q[w_lk_idx] == w_lk_tag);
    assign pred_taken = pred_hit && ctr_q[w_lk_idx][1];
    assign npc        = pred_taken ? {tgt_q[w_lk_idx], 2'b00} : pc_q + XLEN'(4);

    always_comb begin
        pc_d = pc_q;
        if (en) begin
            if (redirect_valid) begin
                pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            end else if (!stall) begin
                pc_d = npc;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        if (upd_valid) begin
            if (w_up_hit) begin
                if (upd_taken) begin
                    if (ctr_q[w_up_idx] != 2'b11) begin
                        ctr_d[w_up_idx] = ctr_q[w_up_idx] + 2'b01;
                    end
                    tgt_d[w_up_idx] = upd_target[XLEN-1:2];
                end else if (ctr_q[w_up_idx] != 2'b00) begin
                    ctr_d[w_up_idx] = ctr_q[w_up_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                // New entries start weakly taken and evict any aliasing entry.
                valid_d[w_up_idx] = 1'b1;
                tag_d[w_up_idx]   = w_up_tag;
                tgt_d[w_up_idx]   = upd_target[XLEN-1:2];
                ctr_d[w_up_idx]   = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            valid_q <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    // Payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
        ctr_q <= ctr_d;
    end

endmodule
`default_nettype wire
